// File: rtl/uc_runctl.sv
// rtl/uc_runctl.sv - microcontroller control unit with run/stop/step/halt sequencing
// Optional UC_INSTRET_EN adds the instret retired-instruction counter.
module uc_runctl #(
  parameter bit RESET_RUN       = 1'b0,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        stop,
  input  logic [5:0]  Opcode,
  input  logic        z,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  Op,
  output logic        pc_we,
  output logic        running,
  output logic        halted,
`ifdef UC_INSTRET_EN
  output logic [15:0] instret,
`endif
  output logic        illegal
);

  typedef enum logic [1:0] {PAUSE, RUN, STEP, HALTED} state_t;

  localparam state_t RESET_STATE = RESET_RUN ? RUN : PAUSE;

  state_t state;
  logic   exec;
  logic   is_alu, is_li, is_j, is_jz, is_jnz, is_nop, is_halt, is_illegal;
  logic   halt_now;

  assign is_alu     = (Opcode[5:3] == 3'b000);
  assign is_li      = (Opcode == 6'b001000);
  assign is_j       = (Opcode == 6'b010000);
  assign is_jz      = (Opcode == 6'b010001);
  assign is_jnz     = (Opcode == 6'b010010);
  assign is_nop     = (Opcode == 6'b111111);
  assign is_halt    = (Opcode == 6'b111110);
  assign is_illegal = ~(is_alu | is_li | is_j | is_jz | is_jnz | is_nop | is_halt);

  // Reset gates exec so enables drop immediately, even while state holds RUN.
  assign exec     = reset & ((state == RUN) | (state == STEP));
  assign halt_now = exec & (is_halt | (HALT_ON_ILLEGAL & is_illegal));

  assign running = (state == RUN);
  assign halted  = (state == HALTED);

  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = 3'b000;
    pc_we = 1'b0;
    if (exec) begin
      pc_we = ~halt_now;
      if (is_alu) begin
        Op  = Opcode[2:0];
        we3 = 1'b1;
        wez = 1'b1;
      end else if (is_li) begin
        we3   = 1'b1;
        s_inm = 1'b1;
      end else if (is_j) begin
        s_inc = 1'b0;
      end else if (is_jz) begin
        s_inc = ~z;
      end else if (is_jnz) begin
        s_inc = z;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RESET_STATE;
      illegal <= 1'b0;
    end else begin
      if (exec && is_illegal)
        illegal <= 1'b1;
      case (state)
        PAUSE: begin
          if (stop)      state <= PAUSE;
          else if (step) state <= STEP;
          else if (run)  state <= RUN;
        end
        RUN: begin
          // The current instruction commits before a stop takes effect.
          if (halt_now)  state <= HALTED;
          else if (stop) state <= PAUSE;
        end
        STEP:    state <= halt_now ? HALTED : PAUSE;
        default: state <= HALTED;
      endcase
    end
  end

`ifdef UC_INSTRET_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      instret <= 16'h0000;
    else if (pc_we)
      instret <= instret + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_uc_runctl.sv
// tb/tb_uc_runctl.sv - scoreboard bench for uc_runctl (default and RESET_RUN/HALT_ON_ILLEGAL builds)
module tb_uc_runctl;

  logic       clk = 1'b0;
  logic       reset, run, step, stop, z;
  logic [5:0] opcode;

  logic       s_inc1, s_inm1, we31, wez1, pc_we1, running1, halted1, illegal1;
  logic [2:0] op1;
  logic       s_inc2, s_inm2, we32, wez2, pc_we2, running2, halted2, illegal2;
  logic [2:0] op2;
`ifdef UC_INSTRET_EN
  logic [15:0] instret1, instret2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] sb[$];

  localparam logic [5:0] NOP = 6'b111111;

  always #5 clk = ~clk;

  uc_runctl #(.RESET_RUN(1'b0), .HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .stop(stop),
    .Opcode(opcode), .z(z),
    .s_inc(s_inc1), .s_inm(s_inm1), .we3(we31), .wez(wez1), .Op(op1),
    .pc_we(pc_we1), .running(running1), .halted(halted1),
`ifdef UC_INSTRET_EN
    .instret(instret1),
`endif
    .illegal(illegal1)
  );

  uc_runctl #(.RESET_RUN(1'b1), .HALT_ON_ILLEGAL(1'b1)) dut2 (
    .clk(clk), .reset(reset), .run(run), .step(step), .stop(stop),
    .Opcode(opcode), .z(z),
    .s_inc(s_inc2), .s_inm(s_inm2), .we3(we32), .wez(wez2), .Op(op2),
    .pc_we(pc_we2), .running(running2), .halted(halted2),
`ifdef UC_INSTRET_EN
    .instret(instret2),
`endif
    .illegal(illegal2)
  );

  function automatic logic [10:0] pk(bit si, bit sm, bit w3, bit wz, bit [2:0] op,
                                     bit pw, bit rn, bit hl, bit il);
    return {si, sm, w3, wz, op, pw, rn, hl, il};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, compare mid-cycle.
  task automatic apply(bit d2, string tag, logic rst, logic [5:0] op, logic zz,
                       logic r, logic sp, logic st, logic [10:0] exp);
    logic [10:0] obs;
    reset  = rst;
    opcode = op;
    z      = zz;
    run    = r;
    step   = sp;
    stop   = st;
    sb.push_back(exp);
    @(negedge clk);
    obs = d2 ? {s_inc2, s_inm2, we32, wez2, op2, pc_we2, running2, halted2, illegal2}
             : {s_inc1, s_inm1, we31, wez1, op1, pc_we1, running1, halted1, illegal1};
    check(tag, {21'd0, obs}, {21'd0, sb.pop_front()});
    @(posedge clk);
    #1;
  endtask

  logic [10:0] idle, exec3, run_base;

  initial begin
    idle     = pk(1, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    exec3    = pk(1, 0, 1, 1, 3'b011, 1, 0, 0, 0);
    run_base = pk(1, 0, 0, 0, 3'b000, 1, 1, 0, 0);
    reset = 1'b0; run = 1'b0; step = 1'b0; stop = 1'b0; z = 1'b0; opcode = 6'b000010;
    @(posedge clk);
    #1;

    apply(0, "rst_hold", 0, 6'b000010, 0, 0, 0, 0, idle);
    apply(0, "rst_hold", 0, 6'b000010, 0, 0, 0, 0, idle);
    for (int i = 0; i < 3; i++)
      apply(0, "pause_idle", 1, 6'b000010, 0, 0, 0, 0, idle);

    apply(0, "step_pulse", 1, 6'b000011, 0, 0, 1, 0, idle);
    apply(0, "step_exec",  1, 6'b000011, 0, 0, 0, 0, exec3);
    apply(0, "step_back",  1, 6'b000011, 0, 0, 0, 0, idle);
    for (int i = 0; i < 4; i++)
      apply(0, "step_held", 1, 6'b000011, 0, 0, 1, 0, (i % 2) ? exec3 : idle);
    apply(0, "step_release", 1, 6'b000011, 0, 0, 0, 0, idle);

    apply(0, "run_req",  1, NOP,       0, 1, 0, 0, idle);
    apply(0, "jz_taken", 1, 6'b010001, 1, 0, 0, 0, pk(0, 0, 0, 0, 3'b000, 1, 1, 0, 0));
    apply(0, "jz_fall",  1, 6'b010001, 0, 0, 0, 0, run_base);
    apply(0, "jnz_fall", 1, 6'b010010, 1, 0, 0, 0, run_base);
    apply(0, "jnz_take", 1, 6'b010010, 0, 0, 0, 0, pk(0, 0, 0, 0, 3'b000, 1, 1, 0, 0));
    apply(0, "jump",     1, 6'b010000, 0, 0, 0, 0, pk(0, 0, 0, 0, 3'b000, 1, 1, 0, 0));
    apply(0, "li",       1, 6'b001000, 0, 0, 0, 0, pk(1, 1, 1, 0, 3'b000, 1, 1, 0, 0));
    apply(0, "alu_stop", 1, 6'b000101, 0, 0, 0, 1, pk(1, 0, 1, 1, 3'b101, 1, 1, 0, 0));
    apply(0, "stop_prio", 1, 6'b000101, 0, 1, 0, 1, idle);
    apply(0, "stopped",  1, 6'b000101, 0, 0, 0, 0, idle);

    apply(0, "run_req2",     1, NOP,       0, 1, 0, 0, idle);
    apply(0, "illegal_exec", 1, 6'b101010, 0, 0, 0, 0, run_base);
    apply(0, "illegal_sticky", 1, NOP,     0, 0, 0, 0, pk(1, 0, 0, 0, 3'b000, 1, 1, 0, 1));
    apply(0, "halt_exec",    1, 6'b111110, 0, 0, 0, 0, pk(1, 0, 0, 0, 3'b000, 0, 1, 0, 1));
    apply(0, "halted_poke",  1, NOP,       0, 1, 1, 0, pk(1, 0, 0, 0, 3'b000, 0, 0, 1, 1));
    apply(0, "halted_hold",  1, NOP,       0, 0, 0, 0, pk(1, 0, 0, 0, 3'b000, 0, 0, 1, 1));
    apply(0, "halt_rst",     0, NOP,       0, 0, 0, 0, idle);
    apply(0, "after_rst",    1, NOP,       0, 0, 0, 0, idle);

    apply(0, "step_pulse2",   1, 6'b000011, 0, 0, 1, 0, idle);
    apply(0, "step_rst",      0, 6'b000011, 0, 0, 0, 0, idle);
    apply(0, "post_step_rst", 1, 6'b000011, 0, 0, 0, 0, idle);

    apply(1, "r2_rst",     0, NOP,       0, 0, 0, 0, pk(1, 0, 0, 0, 3'b000, 0, 1, 0, 0));
    apply(1, "r2_run",     1, NOP,       0, 0, 0, 0, run_base);
    apply(1, "hoi_exec",   1, 6'b101010, 0, 0, 0, 0, pk(1, 0, 0, 0, 3'b000, 0, 1, 0, 0));
    apply(1, "hoi_halted", 1, NOP,       0, 1, 1, 0, pk(1, 0, 0, 0, 3'b000, 0, 0, 1, 1));

`ifdef UC_INSTRET_EN
    reset = 1'b0; run = 1'b0; step = 1'b0; stop = 1'b0; opcode = NOP;
    @(posedge clk);
    #1;
    reset = 1'b1;
    run   = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    check("instret_start", {16'd0, instret1}, 32'h0000);
    repeat (65535) @(posedge clk);
    #1;
    check("instret_ffff", {16'd0, instret1}, 32'hFFFF);
    @(posedge clk);
    #1;
    check("instret_wrap", {16'd0, instret1}, 32'h0000);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check("instret_stop", {16'd0, instret1}, 32'h0001);
    check("instret_paused", {31'd0, running1}, 32'h0);
    @(posedge clk);
    #1;
    check("instret_hold", {16'd0, instret1}, 32'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
